yacc_access_ctrl: RTL and testbench

YACC_ACCESS_CTRL -- requirements
Module: yacc_access_ctrl

---
 rtl/yacc_access_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_yacc_access_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/yacc_access_ctrl.sv
// ---------------------------------------------------------------------------
// yacc_access_ctrl
//
// Access controller in front of a YACC (yet another compressed cache) core.
// Two read requesters (req0 = demand, req1 = prefetch) compete for a single
// transaction slot. The accepted address is looked up in the cache core. On a
// miss the 64-byte line is fetched from memory, its compression factor is
// derived, and the line is handed to the cache core for insertion. Every
// accepted request ends with a one-cycle response pulse.
//
// Only one transaction is in flight at a time:
//   IDLE -> LOOKUP -> RESP                          (hit)
//   IDLE -> LOOKUP -> MEMREQ -> MEMWAIT -> FILL -> RESP  (miss)
//
// Parameters
//   RR_EN          1 = round-robin between requesters, 0 = req0 always wins
//
// Configuration macro
//   YACC_PERF_CNT_EN  when defined, hit_cnt/miss_cnt are saturating 32-bit
//                     counters; when undefined no counter flops exist and
//                     both outputs are tied to 0.
//
// Ports
//   clock, reset       single rising-edge clock, async active-high reset
//   req0_*             demand requester: valid/addr in, ready out
//   req1_*             prefetch requester: valid/addr in, ready out
//   lk_valid/lk_addr   level-held lookup strobe and latched address
//   lk_done/lk_hit     lookup completion pulse and hit flag from the core
//   mem_req_*          line fetch request (line-aligned address)
//   mem_rsp_*          line return pulse and 512-bit data
//   fill_valid/data/cf level-held insert request, registered line and CF
//   fill_done          insert completion pulse from the core
//   rsp_valid/id/hit   one-cycle completion pulse, requester id, hit flag
//   hit_cnt/miss_cnt   completion counters (see YACC_PERF_CNT_EN)
// ---------------------------------------------------------------------------
module yacc_access_ctrl #(
  parameter bit RR_EN = 1'b1
) (
  input  logic         clock,
  input  logic         reset,

  input  logic         req0_valid,
  input  logic [31:0]  req0_addr,
  output logic         req0_ready,

  input  logic         req1_valid,
  input  logic [31:0]  req1_addr,
  output logic         req1_ready,

  output logic         lk_valid,
  output logic [31:0]  lk_addr,
  input  logic         lk_done,
  input  logic         lk_hit,

  output logic         mem_req_valid,
  output logic [31:0]  mem_req_addr,
  input  logic         mem_req_ready,
  input  logic         mem_rsp_valid,
  input  logic [511:0] mem_rsp_data,

  output logic         fill_valid,
  output logic [511:0] fill_data,
  output logic [1:0]   fill_cf,
  input  logic         fill_done,

  output logic         rsp_valid,
  output logic         rsp_id,
  output logic         rsp_hit,

  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEMREQ,
    MEMWAIT,
    FILL,
    RESP
  } state_t;

  // Compression factor encoding of a returned line.
  localparam logic [1:0] CF_X1 = 2'b00;  // upper half populated, no packing
  localparam logic [1:0] CF_X2 = 2'b01;  // fits in the low 256 bits
  localparam logic [1:0] CF_X4 = 2'b10;  // fits in the low 128 bits (or zero)

  state_t state;

  // Set when req1 should win the next tie, i.e. req0 was served last.
  // Cleared by reset so that req0 wins the first tie.
  logic   prio1;

  logic   grant_id;   // requester that would be accepted this cycle
  logic   handshake;  // a request is accepted on this clock edge

  // -------------------------------------------------------------------------
  // Compression factor: the line is classified by how many leading bits are
  // zero. All-zero data falls into the densest class.
  // -------------------------------------------------------------------------
  function automatic logic [1:0] cf_of(input logic [511:0] d);
    logic [1:0] cf;
    if (d[511:128] == '0) begin
      cf = CF_X4;
    end else if (d[511:256] == '0) begin
      cf = CF_X2;
    end else begin
      cf = CF_X1;
    end
    return cf;
  endfunction

  // -------------------------------------------------------------------------
  // Arbitration. Readies are combinational so that a request presented in
  // IDLE is accepted on the very next edge; they are forced low during reset
  // so that every output reads 0 while reset is held.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written in an always_comb gets a default first so
    // that no path leaves it unassigned, which would otherwise infer a latch.
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = RR_EN ? prio1 : 1'b0;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign req0_ready = !reset && (state == IDLE) && req0_valid && !grant_id;
  assign req1_ready = !reset && (state == IDLE) && req1_valid &&  grant_id;
  assign handshake  = req0_ready || req1_ready;

  // The fetch address is always the line containing the lookup address.
  assign mem_req_addr = {lk_addr[31:6], 6'b0};

  // -------------------------------------------------------------------------
  // Transaction FSM. All control outputs are registered here so that they
  // change only on state transitions and stay put while a handshake is
  // pending. Completion pulses from the core and memory are only looked at
  // in the state that is waiting for them.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      prio1         <= 1'b0;
      lk_valid      <= 1'b0;
      lk_addr       <= '0;
      mem_req_valid <= 1'b0;
      fill_valid    <= 1'b0;
      // NOTE: fill_data is a single line register, not a memory array, and
      // must read 0 after reset, so it is reset together with the control
      // state; a true storage array would normally be left unreset.
      fill_data     <= '0;
      fill_cf       <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_hit       <= 1'b0;
    end else begin
      // NOTE: state flops use non-blocking assignments only, so every
      // right-hand side sees the pre-edge value regardless of statement
      // order; the default below is then overridden by the state branches.
      rsp_valid <= 1'b0;

      unique case (state)
        IDLE: begin
          if (handshake) begin
            lk_addr  <= grant_id ? req1_addr : req0_addr;
            rsp_id   <= grant_id;
            prio1    <= !grant_id;
            lk_valid <= 1'b1;
            state    <= LOOKUP;
          end
        end

        LOOKUP: begin
          if (lk_done) begin
            lk_valid <= 1'b0;
            if (lk_hit) begin
              rsp_hit   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              mem_req_valid <= 1'b1;
              state         <= MEMREQ;
            end
          end
        end

        MEMREQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= MEMWAIT;
          end
        end

        MEMWAIT: begin
          if (mem_rsp_valid) begin
            fill_data  <= mem_rsp_data;
            fill_cf    <= cf_of(mem_rsp_data);
            fill_valid <= 1'b1;
            state      <= FILL;
          end
        end

        FILL: begin
          if (fill_done) begin
            fill_valid <= 1'b0;
            rsp_hit    <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end
        end

        RESP: begin
          // rsp_valid was raised on entry and drops by the default above.
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Completion counters. They advance in the RESP cycle, so the new value is
  // visible from the cycle after the response pulse, and stick at all-ones.
  // -------------------------------------------------------------------------
`ifdef YACC_PERF_CNT_EN
  logic [31:0] hit_q;
  logic [31:0] miss_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state == RESP) begin
      if (rsp_hit) begin
        if (hit_q != '1) begin
          hit_q <= hit_q + 32'd1;
        end
      end else begin
        if (miss_q != '1) begin
          miss_q <= miss_q + 32'd1;
        end
      end
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_yacc_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_yacc_access_ctrl
//
// Bench for yacc_access_ctrl. The bench plays both requesters, the cache core
// and the memory. A reference model tracks which requester was served last,
// the expected compression factor of each line and the completion counters.
// A second instance with RR_EN=0 runs alongside with both requesters
// permanently valid and a cache core that always hits.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_yacc_access_ctrl;

`ifdef YACC_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam bit RR_MAIN = 1'b1;

  logic         clock = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0]  req0_addr, req1_addr;
  logic         lk_valid, lk_done, lk_hit;
  logic [31:0]  lk_addr;
  logic         mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic [31:0]  mem_req_addr;
  logic [511:0] mem_rsp_data;
  logic         fill_valid, fill_done;
  logic [511:0] fill_data;
  logic [1:0]   fill_cf;
  logic         rsp_valid, rsp_id, rsp_hit;
  logic [31:0]  hit_cnt, miss_cnt;

  // Fixed-priority instance
  logic         req0_valid_b, req1_valid_b, req0_ready_b, req1_ready_b;
  logic [31:0]  req0_addr_b, req1_addr_b;
  logic         lk_valid_b, lk_done_b, lk_hit_b;
  logic [31:0]  lk_addr_b;
  logic         mem_req_valid_b, mem_req_ready_b, mem_rsp_valid_b;
  logic [31:0]  mem_req_addr_b;
  logic [511:0] mem_rsp_data_b;
  logic         fill_valid_b, fill_done_b;
  logic [511:0] fill_data_b;
  logic [1:0]   fill_cf_b;
  logic         rsp_valid_b, rsp_id_b, rsp_hit_b;
  logic [31:0]  hit_cnt_b, miss_cnt_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int b_rsp_cnt = 0;
  int b_r1_cnt  = 0;

  // Reference model state
  logic        last_served = 1'b1;  // pretend req1 went last so req0 wins first
  logic [31:0] hit_exp  = '0;
  logic [31:0] miss_exp = '0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  yacc_access_ctrl #(.RR_EN(RR_MAIN)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_done(lk_done), .lk_hit(lk_hit),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
    .fill_valid(fill_valid), .fill_data(fill_data), .fill_cf(fill_cf),
    .fill_done(fill_done),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_hit(rsp_hit),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  yacc_access_ctrl #(.RR_EN(1'b0)) dut_fixed (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid_b), .req0_addr(req0_addr_b), .req0_ready(req0_ready_b),
    .req1_valid(req1_valid_b), .req1_addr(req1_addr_b), .req1_ready(req1_ready_b),
    .lk_valid(lk_valid_b), .lk_addr(lk_addr_b), .lk_done(lk_done_b), .lk_hit(lk_hit_b),
    .mem_req_valid(mem_req_valid_b), .mem_req_addr(mem_req_addr_b),
    .mem_req_ready(mem_req_ready_b), .mem_rsp_valid(mem_rsp_valid_b),
    .mem_rsp_data(mem_rsp_data_b),
    .fill_valid(fill_valid_b), .fill_data(fill_data_b), .fill_cf(fill_cf_b),
    .fill_done(fill_done_b),
    .rsp_valid(rsp_valid_b), .rsp_id(rsp_id_b), .rsp_hit(rsp_hit_b),
    .hit_cnt(hit_cnt_b), .miss_cnt(miss_cnt_b)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // mode 0: only [127:0] populated, 1: [255:128] populated, 2: upper half
  // populated, otherwise all zero
  function automatic logic [511:0] make_line(input int mode);
    logic [511:0] d;
    d = rand512();
    case (mode)
      0:       begin d = d & {384'd0, {128{1'b1}}}; d[0] = 1'b1; end
      1:       begin d[511:256] = '0; d[128 + $urandom_range(127, 0)] = 1'b1; end
      2:       d[256 + $urandom_range(255, 0)] = 1'b1;
      default: d = '0;
    endcase
    return d;
  endfunction

  // Density class of a line by magnitude: below 2^128 packs 4x, below 2^256
  // packs 2x, anything larger does not pack.
  function automatic logic [1:0] exp_cf(input logic [511:0] d);
    if ((d >> 128) == '0) return 2'b10;
    if ((d >> 256) == '0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic coin();
    return ($urandom_range(1, 0) == 1);
  endfunction

  // One complete transaction from IDLE back to IDLE, with the bench acting as
  // cache core and memory. Spurious completion pulses are injected while the
  // controller waits on something else.
  task automatic do_txn(input logic v0, input logic v1,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic hit, input logic [511:0] line,
                        input int d_lk, input int d_mreq, input int d_mrsp, input int d_fill);
    logic        exp_id;
    logic [31:0] exp_addr, exp_line;
    logic        hold_ok;
    int          guard, hs_cyc;

    if (v0 && v1) exp_id = (RR_MAIN && last_served == 1'b0) ? 1'b1 : 1'b0;
    else          exp_id = v1;
    exp_addr = exp_id ? a1 : a0;
    exp_line = exp_addr - (exp_addr % 64);

    @(negedge clock);
    req0_valid = v0; req0_addr = a0; req1_valid = v1; req1_addr = a1;
    #1;
    guard = 0;
    while (!((req0_valid && req0_ready) || (req1_valid && req1_ready)) && guard < 20) begin
      @(negedge clock); #1; guard++;
    end
    check("grant", 512'({req1_ready, req0_ready}), 512'(exp_id ? 2'b10 : 2'b01));
    if (guard >= 20) begin
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    last_served = exp_id;
    hs_cyc = cyc;

    @(posedge clock); #1;
    req0_addr = $urandom; req1_addr = $urandom;   // latched copy must not follow
    check("lk_valid", 512'(lk_valid), 512'(1'b1));
    check("lk_addr", 512'(lk_addr), 512'(exp_addr));
    hold_ok = 1'b1;
    repeat (d_lk - 1) begin
      @(posedge clock); #1;
      hold_ok &= lk_valid && (lk_addr == exp_addr) && !rsp_valid && !req0_ready && !req1_ready;
    end
    @(posedge clock); #1;
    lk_done = 1'b1; lk_hit = hit;
    @(posedge clock); #1;
    lk_done = 1'b0; lk_hit = coin();

    if (!hit) begin
      check("mem_req_valid", 512'(mem_req_valid), 512'(1'b1));
      check("mem_req_addr", 512'(mem_req_addr), 512'(exp_line));
      repeat (d_mreq) begin
        lk_done = coin();
        @(posedge clock); #1;
        hold_ok &= mem_req_valid && (mem_req_addr == exp_line) && !lk_valid && !req0_ready;
      end
      lk_done = 1'b0; mem_req_ready = 1'b1;
      @(posedge clock); #1;
      mem_req_ready = 1'b0;
      repeat (d_mrsp) begin
        lk_done = coin(); fill_done = coin();
        @(posedge clock); #1;
        hold_ok &= !mem_req_valid && !fill_valid && !rsp_valid && !lk_valid;
      end
      lk_done = 1'b0; fill_done = 1'b0;
      mem_rsp_valid = 1'b1; mem_rsp_data = line;
      @(posedge clock); #1;
      mem_rsp_valid = 1'b0; mem_rsp_data = rand512();
      check("fill_valid", 512'(fill_valid), 512'(1'b1));
      check("fill_data", fill_data, line);
      check("fill_cf", 512'(fill_cf), 512'(exp_cf(line)));
      repeat (d_fill) begin
        mem_rsp_valid = coin();
        @(posedge clock); #1;
        hold_ok &= fill_valid && (fill_data == line) && (fill_cf == exp_cf(line)) && !rsp_valid;
      end
      mem_rsp_valid = 1'b0; fill_done = 1'b1;
      @(posedge clock); #1;
      fill_done = 1'b0;
    end

    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rsp_valid", 512'(rsp_valid), 512'(1'b1));
    check("rsp_id", 512'(rsp_id), 512'(exp_id));
    check("rsp_hit", 512'(rsp_hit), 512'(hit));
    if (hit) check("hit_latency", 512'(cyc - hs_cyc), 512'(d_lk + 2));
    check("hold_stable", 512'(hold_ok), 512'(1'b1));
    if (hit) begin
      if (hit_exp != 32'hFFFF_FFFF) hit_exp = hit_exp + 1;
    end else begin
      if (miss_exp != 32'hFFFF_FFFF) miss_exp = miss_exp + 1;
    end

    @(posedge clock); #1;
    check("rsp_one_cycle", 512'(rsp_valid), 512'(1'b0));
    check("hit_cnt", 512'(hit_cnt), 512'(PERF ? hit_exp : 32'd0));
    check("miss_cnt", 512'(miss_cnt), 512'(PERF ? miss_exp : 32'd0));
  endtask

  // Fixed-priority instance: both requesters always pending, core always hits
  // one cycle after the strobe appears. req1 must never be granted.
  initial begin
    req0_valid_b = 1'b1; req1_valid_b = 1'b1;
    req0_addr_b = $urandom; req1_addr_b = $urandom;
    lk_done_b = 1'b0; lk_hit_b = 1'b1;
    mem_req_ready_b = 1'b0; mem_rsp_valid_b = 1'b0; mem_rsp_data_b = '0;
    fill_done_b = 1'b0;
    forever begin
      @(negedge clock);
      if (rsp_valid_b) begin
        check("fixed_prio_rsp_id", 512'(rsp_id_b), 512'(1'b0));
        b_rsp_cnt++;
      end
      if (req1_ready_b) b_r1_cnt++;
      lk_done_b = lk_valid_b && !lk_done_b;
      req0_addr_b = $urandom; req1_addr_b = $urandom;
    end
  end

  initial begin
    logic [31:0] a;
    logic        seen;
    int          v;

    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_addr = $urandom; req1_addr = $urandom;
    lk_done = 1'b0; lk_hit = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = rand512();
    fill_done = 1'b0;
    #1;
    check("reset_ctrl", 512'({req0_ready, req1_ready, lk_valid, mem_req_valid, fill_valid,
                              rsp_valid, rsp_id, rsp_hit, fill_cf}), '0);
    check("reset_lk_addr", 512'(lk_addr), '0);
    check("reset_fill_data", fill_data, '0);
    check("reset_counters", 512'({hit_cnt, miss_cnt}), '0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;

    // Demand hit at 0x140 with the core answering one cycle after the strobe
    do_txn(1'b1, 1'b0, 32'h0000_0140, $urandom, 1'b1, '0, 1, 0, 0, 0);
    // Prefetch miss, memory accepts after 2 cycles, only low 128 bits set
    do_txn(1'b0, 1'b1, $urandom, 32'h1234_5678, 1'b0, make_line(0), 1, 2, 1, 1);
    // Remaining CF classes
    do_txn(1'b1, 1'b0, $urandom, $urandom, 1'b0, make_line(1), 2, 0, 0, 0);
    a = $urandom;
    begin
      logic [511:0] top;
      top = rand512(); top[511] = 1'b1;
      do_txn(1'b1, 1'b0, a, $urandom, 1'b0, top, 1, 1, 2, 2);
    end
    do_txn(1'b0, 1'b1, $urandom, $urandom, 1'b0, make_line(3), 1, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      v = $urandom_range(3, 1);
      do_txn(v[0], v[1], $urandom, $urandom, coin(), make_line($urandom_range(3, 0)),
             $urandom_range(3, 1), $urandom_range(3, 0), $urandom_range(3, 0),
             $urandom_range(3, 0));
    end

    // Continuous contention: grants must alternate
    for (int i = 0; i < 4; i++)
      do_txn(1'b1, 1'b1, $urandom, $urandom, coin(), make_line(2), 1, 0, 0, 0);

    // Abort a miss in MEMWAIT with an asynchronous reset
    a = $urandom | 32'h0000_0001;
    @(negedge clock);
    req0_valid = 1'b1; req0_addr = a; req1_valid = 1'b0;
    #1;
    check("abort_ready", 512'(req0_ready), 512'(1'b1));
    @(posedge clock); #1;
    req0_valid = 1'b0; lk_done = 1'b1; lk_hit = 1'b0;
    @(posedge clock); #1;
    lk_done = 1'b0; mem_req_ready = 1'b1;
    @(posedge clock); #1;
    mem_req_ready = 1'b0;
    check("abort_in_memwait", 512'({lk_valid, mem_req_valid, fill_valid, rsp_valid}), '0);
    check("abort_lk_addr_held", 512'(lk_addr), 512'(a));
    #2;
    req0_valid = 1'b1; req1_valid = 1'b1;
    reset = 1'b1;
    #1;
    check("abort_reset_ctrl", 512'({req0_ready, req1_ready, lk_valid, mem_req_valid, fill_valid,
                                    rsp_valid, rsp_id, rsp_hit, fill_cf}), '0);
    check("abort_reset_lk_addr", 512'(lk_addr), '0);
    check("abort_reset_mem_addr", 512'(mem_req_addr), '0);
    check("abort_reset_fill_data", fill_data, '0);
    check("abort_reset_counters", 512'({hit_cnt, miss_cnt}), '0);
    seen = 1'b0;
    repeat (3) begin
      mem_rsp_valid = 1'b1; mem_rsp_data = rand512(); fill_done = 1'b1;
      @(posedge clock); #1;
      seen |= rsp_valid || fill_valid || lk_valid;
    end
    mem_rsp_valid = 1'b0; fill_done = 1'b0;
    check("abort_no_response", 512'(seen), '0);
    last_served = 1'b1; hit_exp = '0; miss_exp = '0;
    #1 reset = 1'b0;

    // First edge after reset accepts; the tie goes back to req0
    do_txn(1'b1, 1'b1, $urandom, $urandom, 1'b1, '0, 1, 0, 0, 0);
    do_txn(1'b1, 1'b0, $urandom, $urandom, 1'b0, make_line(1), 1, 0, 1, 0);
    for (int i = 0; i < 4; i++)
      do_txn(1'b1, 1'b1, $urandom, $urandom, coin(), make_line(0), 1, 0, 0, 0);

`ifdef YACC_PERF_CNT_EN
    // Saturation: preload the hit counter at all-ones, one more hit
    force dut.hit_q = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    release dut.hit_q;
    hit_exp = 32'hFFFF_FFFF;
    check("hit_preload", 512'(hit_cnt), 512'(32'hFFFF_FFFF));
    do_txn(1'b1, 1'b0, $urandom, $urandom, 1'b1, '0, 1, 0, 0, 0);
`endif

    @(negedge clock);
    check("fixed_prio_req1_never_ready", 512'(b_r1_cnt), '0);
    check("fixed_prio_progress", 512'(b_rsp_cnt > 20), 512'(1'b1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
